// File: rtl/sprite_palette_sched_if.sv
// Bus bundle between the sprite index logic, the shared palette and the layer scheduler.
// The master side drives the pixel strobe, layer inputs and palette colour; the slave is the scheduler.
interface sprite_palette_sched_if #(
  parameter int unsigned N_LAYERS = 4
);
  logic                    pix_start;
  logic [N_LAYERS-1:0]     layer_valid;
  logic [8*N_LAYERS-1:0]   layer_index;
  logic [11:0]             bg_rgb;
  logic [7:0]              pal_index;
  logic [11:0]             pal_rgb;
  logic [11:0]             rgb_out;
  logic                    rgb_valid;
  logic                    busy;
  logic                    overrun;
  logic                    clr_overrun;

  modport master (
    output pix_start, layer_valid, layer_index, bg_rgb, pal_rgb, clr_overrun,
    input  pal_index, rgb_out, rgb_valid, busy, overrun
  );

  modport slave (
    input  pix_start, layer_valid, layer_index, bg_rgb, pal_rgb, clr_overrun,
    output pal_index, rgb_out, rgb_valid, busy, overrun
  );
endinterface

// File: rtl/sprite_palette_sched.sv
// Per-pixel layer scheduler sharing one combinational palette lookup across N_LAYERS layers.
// Optional macro PALETTE_KEY_EN: palette colour equal to KEY_RGB is treated as transparent.
module sprite_palette_sched #(
  parameter int unsigned N_LAYERS   = 4,
  parameter logic [11:0] KEY_RGB    = 12'h000,
  parameter logic [11:0] BG_DEFAULT = 12'h000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  sprite_palette_sched_if.slave  bus
);

  localparam int unsigned PtrW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                        r_state;
  logic [PtrW-1:0]               r_ptr;
  logic [N_LAYERS-1:0]           r_cap_valid;
  logic [N_LAYERS-1:0][7:0]      r_cap_index;
  logic [11:0]                   r_cap_bg;
  logic [11:0]                   r_rgb_out;
  logic                          r_rgb_valid;
  logic                          r_overrun;

  logic                          w_opaque;
  logic                          w_hit;
  logic                          w_last;
  logic                          w_overrun_evt;
  logic [7:0]                    w_pal_index;

`ifdef PALETTE_KEY_EN
  assign w_opaque = (bus.pal_rgb != KEY_RGB);
`else
  logic w_key_unused;
  assign w_key_unused = ^KEY_RGB;
  assign w_opaque     = 1'b1;
`endif

  // Palette address comes only from captured state, never from the live layer inputs.
  assign w_pal_index   = (r_state == StScan) ? r_cap_index[r_ptr] : 8'h00;
  assign w_hit         = r_cap_valid[r_ptr] && w_opaque;
  assign w_last        = (r_ptr == PtrW'(N_LAYERS - 1));
  assign w_overrun_evt = bus.pix_start && (r_state == StScan);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= StIdle;
      r_ptr       <= '0;
      r_cap_valid <= '0;
      r_cap_index <= '0;
      r_cap_bg    <= '0;
      r_rgb_out   <= BG_DEFAULT;
      r_rgb_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_rgb_valid <= 1'b0;

      // A new overrun event wins over a simultaneous clear.
      if (w_overrun_evt) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_overrun) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        StIdle, StDone: begin
          if (bus.pix_start) begin
            r_cap_valid <= bus.layer_valid;
            r_cap_index <= bus.layer_index;
            r_cap_bg    <= bus.bg_rgb;
            r_ptr       <= '0;
            r_state     <= StScan;
          end else begin
            r_state     <= StIdle;
          end
        end
        StScan: begin
          if (w_hit) begin
            r_rgb_out   <= bus.pal_rgb;
            r_rgb_valid <= 1'b1;
            r_state     <= StDone;
          end else if (w_last) begin
            r_rgb_out   <= r_cap_bg;
            r_rgb_valid <= 1'b1;
            r_state     <= StDone;
          end else begin
            r_ptr       <= r_ptr + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.pal_index = w_pal_index;
  assign bus.rgb_out   = r_rgb_out;
  assign bus.rgb_valid = r_rgb_valid;
  assign bus.busy      = (r_state == StScan);
  assign bus.overrun   = r_overrun;

endmodule
